// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
// Rebuilds the pixel coordinate from a pixel-rate hs/vs/blank stream and
// checks that stream against the 800x525 (640x480 visible) frame timing.
// Reports lock status, one-cycle error pulses and a saturating lock-loss count.
// Optional feature: define VGA_MON_BLANK_CHECK_EN to build in the blank check.
// With the macro undefined, blank is ignored and blank_err is tied low.
// Timing constants are parameters. Their defaults are the standard geometry.
// state_dbg exposes the FSM state: 0 SEARCH, 1 HALIGN, 2 COUNT, 3 LOCKED.
module vga_timing_monitor #(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int H_VISIBLE    = 640,
  parameter int V_VISIBLE    = 480,
  parameter int H_SYNC_START = 656,
  parameter int V_SYNC_START = 490,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       hs,
  input  logic       vs,
  input  logic       blank,
  output logic [9:0] PixX,
  output logic [9:0] PixY,
  output logic       pix_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic       blank_err,
  output logic [7:0] err_count,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HALIGN = 2'd1,
    COUNT  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
  localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  state_t     state, state_nx;
  logic [3:0] good_cnt, good_nx;
  logic       cnt_inc;
  logic       hs_d, vs_d;
  logic       hs_fall, vs_fall;
  logic [9:0] pred_x, pred_y;
  logic       h_err_c, v_err_c, blank_err_c, any_err;

  assign hs_fall = hs_d & ~hs;
  assign vs_fall = vs_d & ~vs;

  // Predicted coordinate of the pixel being presented this cycle
  always_comb begin
    pred_x = (PixX == H_LAST) ? 10'd0 : PixX + 10'd1;
    pred_y = PixY;
    if (pred_x == 10'd0) begin
      pred_y = (PixY == V_LAST) ? 10'd0 : PixY + 10'd1;
    end
  end

  // Timing checks against the prediction; silent until hs has been seen
  always_comb begin
    h_err_c     = 1'b0;
    v_err_c     = 1'b0;
    blank_err_c = 1'b0;
    if (state != SEARCH) begin
      h_err_c = hs_fall && (pred_x != H_SS);
      v_err_c = vs_fall && ((pred_y != V_SS) || (pred_x != 10'd0));
    end
`ifdef VGA_MON_BLANK_CHECK_EN
    if ((state == COUNT) || (state == LOCKED)) begin
      blank_err_c = blank != ((pred_x < H_VIS) && (pred_y < V_VIS));
    end
`endif
  end

`ifndef VGA_MON_BLANK_CHECK_EN
  logic unused_blank;
  assign unused_blank = blank;
`endif

  assign any_err = h_err_c | v_err_c | blank_err_c;

  // Sync edge history and coordinate counters with sync reloads
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      PixX <= 10'd0;
      PixY <= 10'd0;
    end else begin
      hs_d <= hs;
      vs_d <= vs;
      PixX <= hs_fall ? H_SS : pred_x;
      PixY <= vs_fall ? V_SS : pred_y;
    end
  end

  // Registered error pulses and saturating lock-loss counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      h_err     <= 1'b0;
      v_err     <= 1'b0;
      blank_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      h_err     <= h_err_c;
      v_err     <= v_err_c;
      blank_err <= blank_err_c;
      if (cnt_inc && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  // FSM state register and good-frame counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= SEARCH;
      good_cnt <= 4'd0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_nx;
    end
  end

  // FSM next state: align on hs, start counting on vs, lock after clean frames
  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    cnt_inc  = 1'b0;
    case (state)
      SEARCH: begin
        if (hs_fall) state_nx = HALIGN;
      end
      HALIGN: begin
        // A misplaced hs keeps us realigning. A vs edge starts frame counting.
        if (!h_err_c && vs_fall) begin
          state_nx = COUNT;
          good_nx  = 4'd0;
        end
      end
      COUNT: begin
        if (any_err) begin
          state_nx = HALIGN;
          good_nx  = 4'd0;
        end else if (vs_fall) begin
          good_nx = good_cnt + 4'd1;
          if (good_nx == LOCK_N) state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (any_err) begin
          state_nx = HALIGN;
          good_nx  = 4'd0;
          cnt_inc  = 1'b1;
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  // FSM outputs and coordinate-derived flags
  always_comb begin
    state_dbg   = state;
    locked      = (state == LOCKED);
    pix_valid   = locked && (PixX < H_VIS) && (PixY < V_VIS);
    frame_start = locked && (PixX == 10'd0) && (PixY == 10'd0);
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor
// Directed bench for vga_timing_monitor on a scaled 40x12 frame geometry:
// 32x8 visible, hs low at X 34..37, vs low on lines 9..10, and LOCK_FRAMES 2.
// The bench has its own stream generator (hc/vc/fr). Each expected value comes
// from the generator position and from values worked out by hand.
`timescale 1ns/1ps
module tb_vga_timing_monitor;

  localparam int HT = 40, VT = 12, HV = 32, VV = 8;
  localparam int HSS = 34, HSW = 4, VSS = 9, VSW = 2, LOCKF = 2;

  logic       Clk = 1'b0;
  logic       Reset, hs, vs, blank;
  logic [9:0] PixX, PixY;
  logic       pix_valid, frame_start, locked, h_err, v_err, blank_err;
  logic [7:0] err_count;
  logic [1:0] state_dbg;

  vga_timing_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_VISIBLE(HV), .V_VISIBLE(VV),
    .H_SYNC_START(HSS), .V_SYNC_START(VSS), .LOCK_FRAMES(LOCKF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .hs(hs), .vs(vs), .blank(blank),
    .PixX(PixX), .PixY(PixY), .pix_valid(pix_valid), .frame_start(frame_start),
    .locked(locked), .h_err(h_err), .v_err(v_err), .blank_err(blank_err),
    .err_count(err_count), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 Clk = ~Clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Generator position (next pixel to present) and last presented pixel
  int hc = 0, vc = 0, fr = 0;
  int p_hc = 0, p_vc = 0, p_fr = 0;
  bit gen_run = 0;
  bit force_hs_low = 0, force_vs_high = 0, force_blank_low = 0;

  // Event monitors, cleared at the start of each scenario
  int n_herr, n_verr, n_berr, n_fs, n_pv, n_lock, n_track_bad;
  int fs_x, fs_y;
  int n_tests = 0, n_fail = 0;
  int e_fr, n;

  task automatic clr_mon();
    n_herr = 0; n_verr = 0; n_berr = 0; n_fs = 0; n_pv = 0;
    n_lock = 0; n_track_bad = 0; fs_x = -1; fs_y = -1;
  endtask

  // Present one pixel, clock it in, then sample outputs 1 ns after the edge
  task automatic step();
    hs    = force_hs_low    ? 1'b0 : !(hc >= HSS && hc < HSS + HSW);
    vs    = force_vs_high   ? 1'b1 : !(vc >= VSS && vc < VSS + VSW);
    blank = force_blank_low ? 1'b0 : (hc < HV && vc < VV);
    @(posedge Clk);
    #1;
    p_hc = hc; p_vc = vc; p_fr = fr;
    if (gen_run) begin
      if (hc == HT - 1) begin
        hc = 0;
        if (vc == VT - 1) begin vc = 0; fr++; end
        else vc++;
      end else begin
        hc++;
      end
    end
    if (h_err) n_herr++;
    if (v_err) n_verr++;
    if (blank_err) n_berr++;
    if (pix_valid) n_pv++;
    if (frame_start) begin n_fs++; fs_x = p_hc; fs_y = p_vc; end
    if (locked) begin
      n_lock++;
      if (int'(PixX) != p_hc || int'(PixY) != p_vc) n_track_bad++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_lock(input int budget);
    n = 0;
    while (!locked && n < budget) begin step(); n++; end
  endtask

  // Directed sequence
  initial begin
    Reset = 1'b1; hs = 1'b1; vs = 1'b1; blank = 1'b0;
    clr_mon();
    repeat (2) step();
    chk("rst_pixx", PixX, 0);
    chk("rst_pixy", PixY, 0);
    chk("rst_locked", locked, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_pulses", {h_err, v_err, blank_err, frame_start, pix_valid}, 0);

    // Conforming stream from (0,0). The first hs fall is at X=34 and aligns X.
    Reset = 1'b0; gen_run = 1;
    clr_mon();
    repeat (35) step();
    chk("halign_state", state_dbg, 1);
    chk("halign_pixx", PixX, HSS);
    step();
    chk("latency_pixx", PixX, HSS + 1);
    wait_lock(3000);
    chk("lock1_locked", locked, 1);
    chk("lock1_frame", p_fr, 2);
    chk("lock1_line", p_vc, VSS);
    chk("lock1_col", p_hc, 0);
    chk("lock1_state", state_dbg, 3);
    chk("lock1_errs", n_herr + n_verr + n_berr, 0);

    // One full locked frame: wraps, frame_start, pix_valid count
    while (!(hc == 0 && vc == 0)) step();
    clr_mon();
    repeat (HT * VT) step();
    chk("frame_track", n_track_bad, 0);
    chk("frame_locked", n_lock, HT * VT);
    chk("frame_fs_cnt", n_fs, 1);
    chk("frame_fs_pos", {fs_x[15:0], fs_y[15:0]}, 0);
    chk("frame_pv_cnt", n_pv, HV * VV);
    chk("frame_errs", n_herr + n_verr + n_berr, 0);
    chk("wrap_pixx", PixX, HT - 1);
    chk("wrap_pixy", PixY, VT - 1);
    step();
    chk("wrap_pixx0", PixX, 0);
    chk("wrap_pixy0", PixY, 0);

    // Early hs fall at X=33: error, then a second h_err on the next line, relock
    while (!(vc == 3 && hc == HSS - 1)) step();
    clr_mon();
    e_fr = fr;
    force_hs_low = 1;
    step();
    force_hs_low = 0;
    chk("herr_pulse", h_err, 1);
    chk("herr_locked", locked, 0);
    chk("herr_errcnt", err_count, 1);
    chk("herr_pixx", PixX, HSS);
    chk("herr_state", state_dbg, 1);
    wait_lock(3000);
    chk("herr_relock", locked, 1);
    chk("herr_relock_frame", p_fr, e_fr + 2);
    chk("herr_relock_line", p_vc, VSS);
    chk("herr_relock_col", p_hc, 0);
    chk("herr_count", n_herr, 2);
    chk("herr_verr", n_verr, 0);
    chk("herr_errcnt2", err_count, 1);

    // Blank forced low at visible pixel (5,10)
    while (!(vc == 5 && hc == 10)) step();
    clr_mon();
    e_fr = fr;
    force_blank_low = 1;
    step();
    force_blank_low = 0;
`ifdef VGA_MON_BLANK_CHECK_EN
    chk("blank_pulse", blank_err, 1);
    chk("blank_locked", locked, 0);
    chk("blank_errcnt", err_count, 2);
    chk("blank_state", state_dbg, 1);
    wait_lock(3000);
    chk("blank_relock", locked, 1);
    chk("blank_relock_frame", p_fr, e_fr + 2);
`else
    chk("blank_pulse", blank_err, 0);
    chk("blank_locked", locked, 1);
    chk("blank_errcnt", err_count, 1);
    repeat (5) step();
    chk("blank_quiet", n_berr, 0);
    chk("blank_stay", locked, 1);
`endif

    // One-cycle reset in mid-frame while locked
    while (!(vc == 4 && hc == 20)) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("mrst_locked", locked, 0);
    chk("mrst_pixx", PixX, 0);
    chk("mrst_pixy", PixY, 0);
    chk("mrst_errcnt", err_count, 0);
    chk("mrst_state", state_dbg, 0);
    chk("mrst_pulses", {h_err, v_err, blank_err, frame_start, pix_valid}, 0);

    // vs held high for three frames: HALIGN only, never locked, no v_err
    clr_mon();
    force_vs_high = 1;
    repeat (3 * HT * VT) step();
    chk("vhigh_state", state_dbg, 1);
    chk("vhigh_lock", n_lock, 0);
    chk("vhigh_verr", n_verr, 0);
    chk("vhigh_herr", n_herr, 0);
    chk("vhigh_fs", n_fs, 0);
    chk("vhigh_pv", n_pv, 0);

    // Release vs. The misaligned Y gives one v_err on the aligning edge, then relock.
    while (!(hc == 0 && vc == 0)) step();
    force_vs_high = 0;
    clr_mon();
    e_fr = fr;
    wait_lock(3000);
    chk("vrel_relock", locked, 1);
    chk("vrel_frame", p_fr, e_fr + 2);
    chk("vrel_verr", n_verr, 1);
    chk("vrel_errcnt", err_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_monitor.md
# vga_timing_monitor

Receive-side counterpart of the VGA timing generator: consumes a pixel-rate hs/vs/blank stream, recovers the current pixel coordinate, and checks the stream against the fixed 800x525 (640x480 visible) timing. It sits on any video path that must re-derive coordinates from sync signals, such as a capture or overlay stage or a loop-back self-check of the display output. It also reports lock status and timing errors.

## Interface
- H_TOTAL, 800, pixel clocks per line
- V_TOTAL, 525, lines per frame
- H_VISIBLE, 640, visible pixels per line
- V_VISIBLE, 480, visible lines per frame
- H_SYNC_START, 656, X coordinate of the first hs-low pixel
- V_SYNC_START, 490, Y coordinate of the first vs-low line
- LOCK_FRAMES, 2, consecutive clean frames required to lock (1..15)

Ports:
- Clk  in  1  pixel clock; the only clock
- Reset  in  1  synchronous, active-high
- hs  in  1  horizontal sync, active-low
- vs  in  1  vertical sync, active-low
- blank  in  1  high = visible pixel
- PixX  out  10  recovered X of the pixel presented on the previous cycle
- PixY  out  10  recovered Y of the pixel presented on the previous cycle
- pix_valid  out  1  locked AND PixX<H_VISIBLE AND PixY<V_VISIBLE
- frame_start  out  1  one-cycle pulse while locked when PixX==0 and PixY==0
- locked  out  1  timing locked
- h_err, v_err, blank_err  out  1 each  one-cycle error pulses
- err_count  out  8  saturating count of lock losses

## Operation
- Reset values:
  - PixX=0, PixY=0; all pulses 0; locked=0; err_count=0; state SEARCH; good-frame counter 0.
  - hs_d=1, vs_d=1, so the first cycle after reset produces no false edges.
- Edges are computed on the current input against the registered previous value.
  - hs_fall = hs_d & ~hs.
  - vs_fall = vs_d & ~vs.
- Predicted X: PixX+1, wrapping from H_TOTAL-1 to 0.
- Predicted Y: PixY+1 when predicted X wraps to 0, else PixY; wraps from V_TOTAL-1 to 0.
- Counter update:
  - On hs_fall: PixX <= H_SYNC_START; otherwise PixX <= predicted X.
  - On vs_fall: PixY <= V_SYNC_START; otherwise PixY <= predicted Y.
  - The two loads are independent. If both occur in the same cycle, both apply.
- Checks (active only outside SEARCH):
  - h_err: hs_fall while predicted X != H_SYNC_START.
  - v_err: vs_fall while predicted Y != V_SYNC_START or predicted X != 0.
  - blank_err (state COUNT or LOCKED only): blank != (predicted X<H_VISIBLE && predicted Y<V_VISIBLE).
- State machine:
  - SEARCH -> HALIGN on the first hs_fall.
  - HALIGN -> COUNT on vs_fall, with the good-frame counter cleared. h_err keeps the state in HALIGN.
  - COUNT: every vs_fall with no error since the previous vs_fall increments the good-frame counter. Reaching LOCK_FRAMES -> LOCKED. Any error -> HALIGN, counter cleared.
  - LOCKED: any error -> HALIGN and err_count increments, saturating at 255.
- The vs_fall that completes a clean frame and enters LOCKED carries no error by definition.

## Timing
- Latency is one cycle: PixX/PixY at cycle t+1 equal the generator's hc/vc at cycle t for a conforming stream.
- Error pulses are registered and assert the cycle after the offending input.
- locked rises the cycle after the qualifying vs_fall and falls the cycle after an error.
- pix_valid and frame_start are derived from the registered PixX, PixY and locked.
- Reset mid-operation: all outputs take their reset values on the next edge, regardless of state.

## Configuration
- VGA_MON_BLANK_CHECK_EN defined: the blank check is built in and blank_err participates in lock decisions.
- VGA_MON_BLANK_CHECK_EN undefined: the blank input is ignored, blank_err is tied 0, and lock depends on hs/vs only.

## Test plan
- Reset, then a conforming 800x525 stream with the first hs_fall at X=656 -> locked rises one cycle after the 3rd vs_fall (one aligning vs_fall plus LOCK_FRAMES=2 clean frames). PixX/PixY then equal the stimulus counters delayed by one cycle, and no error pulses occur.
- Locked stream; one hs_fall arrives at X=655 -> h_err pulses, locked=0, err_count=1, PixX reloads 656. Relock occurs after 1 aligning vs_fall plus 2 clean frames.
- Locked stream with the macro defined; blank forced 0 at (100,100) -> blank_err pulses, locked=0. Same stimulus with the macro undefined -> no pulse and locked stays 1.
- Locked stream -> PixX wraps 799->0 and PixY wraps 524->0. frame_start pulses exactly once per frame, at (0,0). pix_valid is high for exactly 640x480 cycles per frame.
- Reset asserted for one cycle mid-frame while locked -> next cycle locked=0, PixX=0, PixY=0, err_count=0, state SEARCH.
- vs held high and hs conforming -> state stays HALIGN, locked never asserts, v_err never pulses.
